// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default bit timing
// Purpose : constants common to the camera-module UART receiver and transmitter.
// Contents: CLKS_PER_BIT_DEF (125 MHz / 115200 baud), 3-bit FSM state codes.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 1085;

  localparam logic [2:0] s_IDLE    = 3'd0;
  localparam logic [2:0] s_START   = 3'd1;
  localparam logic [2:0] s_DATA    = 3'd2;
  localparam logic [2:0] s_STOP    = 3'd3;
  localparam logic [2:0] s_CLEANUP = 3'd4;
  localparam logic [2:0] s_BREAK   = 3'd5;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte output bundle of the UART receiver
// Purpose : carries received bytes and frame status to the command/camera logic.
// Signals : o_Rx_DV (1-cycle byte strobe), o_Rx_Byte (last good byte),
//           o_Rx_Frame_Err (1-cycle stop-bit error), o_Rx_Active (frame in progress).
// Modports: master = receiver (drives), slave = consumer (reads).
interface uart_rx_if;

  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  modport master (output o_Rx_DV, output o_Rx_Byte, output o_Rx_Frame_Err, output o_Rx_Active);
  modport slave  (input  o_Rx_DV, input  o_Rx_Byte, input  o_Rx_Frame_Err, input  o_Rx_Active);

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous inputs
// Purpose : brings asynchronous camera-side inputs into the i_Clock domain.
// Ports   : i_Clock, i_Rst_n (async, active-low), i_D (async in), o_Q (synchronised out).
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta <= RESET_VAL;
      o_Q  <= RESET_VAL;
    end else begin
      meta <= i_D;
      o_Q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and break recovery
// Purpose : receives 8N1 frames, flags false starts and framing errors.
// Ports   : i_Clock (125 MHz), i_Rst_n (async, active-low), i_Rx_Serial (idle high),
//           rx_if (master): o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 11
) (
  input  logic      i_Clock,
  input  logic      i_Rst_n,
  input  logic      i_Rx_Serial,
  uart_rx_if.master rx_if
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_dv;
  logic [7:0]       rx_byte;
  logic             frame_err;
  logic             rx_active;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= s_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_dv     <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        s_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= s_START;
        end
        s_START: begin
          // Re-check the line half a bit in: a high here means the low was noise.
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              rx_active <= 1'b1;
              state     <= s_DATA;
            end else begin
              state <= s_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        s_DATA: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt         <= '0;
            shift[bit_idx]  <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= s_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        s_STOP: begin
          if (clk_cnt == FULL_CNT) begin
            clk_cnt   <= '0;
            rx_active <= 1'b0;
            if (rx_s) begin
              rx_byte <= shift;
              rx_dv   <= 1'b1;
              state   <= s_CLEANUP;
            end else begin
              frame_err <= 1'b1;
              state     <= s_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        s_CLEANUP: state <= s_IDLE;
        // Wait out a held-low line so it is not taken as a stream of start bits.
        s_BREAK: if (rx_s) state <= s_IDLE;
        default: state <= s_IDLE;
      endcase
    end
  end

  assign rx_if.o_Rx_DV        = rx_dv;
  assign rx_if.o_Rx_Byte      = rx_byte;
  assign rx_if.o_Rx_Frame_Err = frame_err;
  assign rx_if.o_Rx_Active    = rx_active;

endmodule
